// File: rtl/param_pkg.sv
// Shared widths, block geometry and JPEG Annex K (quality 50) quant tables
// for the decode-side dequantizer, all in raster order.
package param_pkg;

  localparam int MCU_SIZE      = 8;
  localparam int QUAN_BITWIDTH = 12;
  localparam int DCT_BITWIDTH  = 16;
  localparam int QTAB_BITWIDTH = 8;
  localparam int BLOCK_COEFS   = MCU_SIZE * MCU_SIZE;

  typedef logic [0:BLOCK_COEFS-1][QTAB_BITWIDTH-1:0] qtab_t;
  typedef logic signed [QUAN_BITWIDTH-1:0]           quan_pix_t;
  typedef logic signed [DCT_BITWIDTH-1:0]            dct_pix_t;

  localparam qtab_t LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam qtab_t CHROMA_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  function automatic bit qtab_nonzero(qtab_t t);
    for (int i = 0; i < BLOCK_COEFS; i++) begin
      if (t[i] == '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // A zero entry would silently erase coefficients; the top refuses to elaborate.
  localparam bit QTABS_OK = qtab_nonzero(LUMA_Q) && qtab_nonzero(CHROMA_Q);

endpackage

// File: rtl/jpeg_dequant_lane.sv
// One channel of dequantization: signed coefficient times unsigned table
// entry, saturated to the DCT output width. Purely combinational.
module jpeg_dequant_lane #(
  parameter int IN_W  = 12,
  parameter int Q_W   = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  coef,
  input  logic        [Q_W-1:0]   q,
  output logic signed [OUT_W-1:0] dq
);

  localparam int P_W = IN_W + Q_W + 1;
  localparam logic signed [P_W-1:0] SAT_MAX = P_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [P_W-1:0] coef_x;
  logic signed [P_W-1:0] q_x;
  logic signed [P_W-1:0] prod;

  // q is zero-extended so a table entry >= 128 never reads as negative.
  assign coef_x = P_W'(coef);
  assign q_x    = P_W'({1'b0, q});
  assign prod   = coef_x * q_x;

  // NOTE: every branch assigns dq, so no latch is inferred.
  always_comb begin
    if (prod > SAT_MAX)      dq = SAT_MAX[OUT_W-1:0];
    else if (prod < SAT_MIN) dq = SAT_MIN[OUT_W-1:0];
    else                     dq = prod[OUT_W-1:0];
  end

endmodule

// File: rtl/jpeg_dequantizer.sv
// Decode-side dequantizer: Y/U/V coefficient stream in raster order, multiplied
// by the per-position quant table entry over a 2-stage valid/ready pipe.
module jpeg_dequantizer
  import param_pkg::*;
#(
  parameter int MCU_SIZE = param_pkg::MCU_SIZE,
  parameter int IN_W     = param_pkg::QUAN_BITWIDTH,
  parameter int OUT_W    = param_pkg::DCT_BITWIDTH,
  parameter int Q_W      = param_pkg::QTAB_BITWIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [3*IN_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [3*OUT_W-1:0] m_data,
  output logic               m_last,
  output logic               err_frame
);

  localparam int POS_W = $clog2(MCU_SIZE * MCU_SIZE);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MCU_SIZE * MCU_SIZE - 1);

  if (!QTABS_OK) begin : g_bad_qtab
    $error("quant table contains a zero entry");
  end

  logic             ready_en;
  logic [POS_W-1:0] pos;
  logic             accept;
  logic             s1_adv;
  logic             s2_adv;

  logic              s1_valid;
  logic [3*IN_W-1:0] s1_data;
  logic [Q_W-1:0]    s1_q_luma;
  logic [Q_W-1:0]    s1_q_chroma;
  logic              s1_last;
  logic              s1_err;
  logic              m_err;

  logic [OUT_W-1:0] dq_y;
  logic [OUT_W-1:0] dq_u;
  logic [OUT_W-1:0] dq_v;

  // A stage moves when the register downstream is empty or draining this cycle.
  assign s2_adv    = !m_valid || m_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign s_ready   = ready_en && s1_adv;
  assign accept    = s_valid && s_ready;
  assign err_frame = m_valid && m_ready && m_err;

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      pos      <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) pos <= s_last ? '0 : pos + 1'b1;
    end
  end

  // NOTE: datapath registers are reset too, since m_data must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_q_luma   <= '0;
      s1_q_chroma <= '0;
      s1_last     <= 1'b0;
      s1_err      <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data     <= s_data;
        s1_q_luma   <= LUMA_Q[pos];
        s1_q_chroma <= CHROMA_Q[pos];
        s1_last     <= (pos == POS_LAST);
        s1_err      <= s_last != (pos == POS_LAST);
      end
    end
  end

  jpeg_dequant_lane #(.IN_W(IN_W), .Q_W(Q_W), .OUT_W(OUT_W)) u_lane_y (
    .coef (s1_data[2*IN_W +: IN_W]),
    .q    (s1_q_luma),
    .dq   (dq_y)
  );

  jpeg_dequant_lane #(.IN_W(IN_W), .Q_W(Q_W), .OUT_W(OUT_W)) u_lane_u (
    .coef (s1_data[IN_W +: IN_W]),
    .q    (s1_q_chroma),
    .dq   (dq_u)
  );

  jpeg_dequant_lane #(.IN_W(IN_W), .Q_W(Q_W), .OUT_W(OUT_W)) u_lane_v (
    .coef (s1_data[0 +: IN_W]),
    .q    (s1_q_chroma),
    .dq   (dq_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_err   <= 1'b0;
    end else if (s2_adv) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_data <= {dq_y, dq_u, dq_v};
        m_last <= s1_last;
        m_err  <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dequantizer.sv
// Self-checking bench for jpeg_dequantizer: directed steps with random data,
// checked against a queue-based model built from plain multiply-and-clamp.
module tb_jpeg_dequantizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [35:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  logic        m_last;
  logic        err_frame;

  always #5 clk = ~clk;

  jpeg_dequantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .err_frame (err_frame)
  );

  typedef struct {
    logic [47:0] d;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_log[$];
  int          total = 0;
  int          bad = 0;
  int          m_pos = 0;
  int          mr_mode = 0;
  int          n_out = 0;
  bit          rdy_live = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [49:0] held;

  int luma[64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int chroma[64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] dq(input logic [11:0] c, input int q);
    int p;
    p = int'($signed(c)) * q;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic logic [35:0] pack(input int y, input int u, input int v);
    return {12'(y), 12'(u), 12'(v)};
  endfunction

  function automatic logic [35:0] rand_data();
    return {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
            12'($urandom_range(0, 4095))};
  endfunction

  task automatic model_accept(input logic [35:0] d, input logic l);
    beat_t e;
    e.d    = {dq(d[35:24], luma[m_pos]), dq(d[23:12], chroma[m_pos]),
              dq(d[11:0], chroma[m_pos])};
    e.last = (m_pos == 63);
    e.err  = (l != (m_pos == 63));
    exp_q.push_back(e);
    m_pos  = l ? 0 : (m_pos + 1) % 64;
  endtask

  // One clock: drive at the falling edge, observe 1 ns later, model the coming rising edge.
  task automatic tick(input logic sv, input logic [35:0] sd, input logic sl, output logic acc);
    logic  mr;
    beat_t e;
    beat_t o;
    @(negedge clk);
    case (mr_mode)
      0:       mr = 1'b1;
      1:       mr = 1'($urandom_range(0, 1));
      default: mr = 1'b0;
    endcase
    s_valid = sv;
    s_data  = sd;
    s_last  = sl;
    m_ready = mr;
    #1;
    if (stalled_prev) check("hold_stable", 64'({m_valid, m_last, m_data}), 64'(held));
    if (rdy_live) check("s_ready", 64'(s_ready), 64'((exp_q.size() < 2) || mr));
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(m_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("m_data", 64'(m_data), 64'(e.d));
        check("m_last", 64'(m_last), 64'(e.last));
        check("err_frame", 64'(err_frame), 64'(e.err));
      end
      o.d = m_data;
      o.last = m_last;
      o.err = err_frame;
      obs_log.push_back(o);
      n_out++;
    end else begin
      check("err_idle", 64'(err_frame), 64'(0));
    end
    stalled_prev = m_valid && !m_ready;
    held = {m_valid, m_last, m_data};
    acc = sv && s_ready;
    if (acc) model_accept(sd, sl);
  endtask

  task automatic send(input logic [35:0] d, input logic l);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      tick(1'b1, d, l, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send(rand_data(), m_pos == 63);
  endtask

  task automatic drain();
    logic acc;
    int   budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      tick(1'b0, '0, 1'b0, acc);
      budget++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic acc;
    int   base;
    int   n0;

    // Reset state
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_err", 64'(err_frame), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b0, acc);
    check("s_ready_after_rst", 64'(s_ready), 64'(1));
    rdy_live = 1'b1;

    // 1: basic value and two-cycle latency
    tick(1'b1, pack(-3, 5, 0), 1'b0, acc);
    check("t1_accept", 64'(acc), 64'(1));
    tick(1'b0, '0, 1'b0, acc);
    check("t1_lat_early", 64'(m_valid), 64'(0));
    tick(1'b0, '0, 1'b0, acc);
    check("t1_lat_valid", 64'(m_valid), 64'(1));
    check("t1_data", 64'(m_data), 64'(48'hFFD0_0055_0000));
    send_rand(63);
    drain();

    // 2: full block, back-to-back
    base = obs_log.size();
    n0 = n_out;
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, (i == 63) ? pack(1, 0, 0) : rand_data(), i == 63, acc);
      check("t2_accept", 64'(acc), 64'(1));
    end
    tick(1'b0, '0, 1'b0, acc);
    tick(1'b0, '0, 1'b0, acc);
    check("t2_back_to_back", 64'(n_out - n0), 64'(64));
    check("t2_pos63_y", 64'(obs_log[base+63].d[47:32]), 64'(99));
    check("t2_last", 64'(obs_log[base+63].last), 64'(1));
    drain();

    // 3: saturation at both table extremes
    base = obs_log.size();
    send(pack(2047, -2048, 2047), 1'b0);
    send_rand(62);
    send(pack(2047, 0, 0), 1'b1);
    send_rand(63);
    send(pack(-2048, 0, 0), 1'b1);
    drain();
    check("t3_pos0_noclip", 64'(obs_log[base].d[47:32]), 64'(16'd32752));
    check("t3_u_neg_clip", 64'(obs_log[base].d[31:16]), 64'(16'h8000));
    check("t3_v_pos_clip", 64'(obs_log[base].d[15:0]), 64'(16'h7FFF));
    check("t3_pos63_max", 64'(obs_log[base+63].d[47:32]), 64'(16'h7FFF));
    check("t3_pos63_min", 64'(obs_log[base+127].d[47:32]), 64'(16'h8000));

    // 4: random backpressure
    mr_mode = 1;
    send_rand(200);
    drain();
    mr_mode = 0;

    // 5: framing errors
    while (m_pos != 10) send_rand(1);
    drain();
    base = obs_log.size();
    send(rand_data(), 1'b1);
    send(pack(1, 1, 1), 1'b0);
    drain();
    check("t5_early_last_err", 64'(obs_log[base].err), 64'(1));
    check("t5_early_last_nolast", 64'(obs_log[base].last), 64'(0));
    check("t5_restart_pos0", 64'(obs_log[base+1].d), 64'({16'd16, 16'd17, 16'd17}));
    check("t5_pulse_one", 64'(obs_log[base+1].err), 64'(0));
    while (m_pos != 63) send(rand_data(), 1'b0);
    drain();
    base = obs_log.size();
    send(rand_data(), 1'b0);
    send(pack(2, 0, 0), 1'b0);
    drain();
    check("t5_missing_last_err", 64'(obs_log[base].err), 64'(1));
    check("t5_missing_last_mlast", 64'(obs_log[base].last), 64'(1));
    check("t5_wrap_pos0", 64'(obs_log[base+1].d[47:32]), 64'(32));

    // 6: reset mid-block with data in flight
    while (m_pos != 30) send_rand(1);
    tick(1'b0, '0, 1'b0, acc);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("t6_inflight", 64'(m_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", 64'(m_valid), 64'(0));
    check("t6_rst_m_data", 64'(m_data), 64'(0));
    check("t6_rst_s_ready", 64'(s_ready), 64'(0));
    exp_q.delete();
    m_pos = 0;
    stalled_prev = 1'b0;
    rdy_live = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b0, acc);
    check("t6_s_ready_back", 64'(s_ready), 64'(1));
    rdy_live = 1'b1;
    base = obs_log.size();
    send(pack(1, 1, 1), 1'b0);
    drain();
    check("t6_pos0_tables", 64'(obs_log[base].d), 64'({16'd16, 16'd17, 16'd17}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
